eth_phy_10g_link_ctrl: RTL and testbench
========================================

ETH_PHY_10G_LINK_CTRL -- requirements
Module: eth_phy_10g_link_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16, meaning: cycles phy_rst is held high in RESET (range 1..65535).
REQ-002 Parameter LOCK_TIMEOUT, default 4096, meaning: max cycles in WAIT_LOCK before retrain (range 1..65535).
REQ-003 Parameter STATUS_TIMEOUT, default 8192, meaning: max cycles in WAIT_STATUS before retrain (range 1..65535).
REQ-004 Parameter LOSS_FILTER, default 4, meaning: consecutive bad cycles in UP that trigger retrain (range 1..255).
REQ-005 Parameter HOLDOFF_CYCLES, default 64, meaning: idle cycles in HOLDOFF before re-reset (range 1..65535).
REQ-006 rx_clk  input  1  sole clock; all logic on rising edge.
REQ-007 rx_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 cfg_enable  input  1  link bring-up enable; low forces IDLE.
REQ-009 force_retrain  input  1  single-cycle request to drop and retrain link.
REQ-010 rx_block_lock  input  1  PHY block lock.
REQ-011 rx_status  input  1  PHY receive status.
REQ-012 rx_high_ber  input  1  PHY high bit-error-rate flag.
REQ-013 phy_rst  output  1  active-high reset to PHY tx/rx paths.
REQ-014 link_up  output  1  high while in UP.
REQ-015 state  output  3  current state encoding.
REQ-016 timeout_pulse  output  1  one-cycle pulse on lock/status timeout.
REQ-017 retrain_count  output  8  saturating count of HOLDOFF entries.

Function
REQ-018 States/encoding SHALL be IDLE=0, RESET=1, WAIT_LOCK=2, WAIT_STATUS=3, UP=4, HOLDOFF=5; codes 6,7 SHALL go to IDLE next cycle.
REQ-019 All outputs SHALL be registered; phy_rst=1 in IDLE and RESET only, link_up=1 in UP only, state mirrors state register.
REQ-020 A 16-bit timer SHALL clear to 0 on every state entry (including WAIT_STATUS->WAIT_LOCK re-entry) and increment each cycle otherwise, saturating at 65535.
REQ-021 Transition priority per cycle SHALL be: cfg_enable=0 -> IDLE; then force_retrain (in WAIT_LOCK, WAIT_STATUS, UP) -> HOLDOFF; then timeout/loss; then progress.
REQ-022 IDLE -> RESET when cfg_enable=1.
REQ-023 RESET -> WAIT_LOCK when timer == RST_CYCLES-1, giving exactly RST_CYCLES cycles of phy_rst=1 in RESET.
REQ-024 WAIT_LOCK -> WAIT_STATUS when rx_block_lock=1; else -> HOLDOFF when timer == LOCK_TIMEOUT-1; lock in the timeout cycle SHALL win.
REQ-025 WAIT_STATUS -> WAIT_LOCK when rx_block_lock=0; else -> UP when rx_status=1; else -> HOLDOFF when timer == STATUS_TIMEOUT-1.
REQ-026 In UP a cycle is bad when rx_status=0 or rx_block_lock=0 or rx_high_ber=1; 8-bit loss counter increments per bad cycle, clears on good cycle and on UP entry; UP -> HOLDOFF in the cycle the LOSS_FILTER-th consecutive bad cycle is sampled.
REQ-027 HOLDOFF -> RESET when timer == HOLDOFF_CYCLES-1; force_retrain ignored in HOLDOFF, IDLE, RESET.
REQ-028 timeout_pulse SHALL be 1 exactly in the first HOLDOFF cycle when entry was caused by REQ-024/REQ-025 timeout, 0 otherwise.
REQ-029 retrain_count SHALL increment by 1 on each HOLDOFF entry (any cause), saturating at 255; cleared only by reset.
REQ-030 Leaving any state to IDLE via cfg_enable=0 SHALL not increment retrain_count nor pulse timeout_pulse.

Reset
REQ-031 On rx_rst_n=0, asynchronously: state=IDLE, phy_rst=1, link_up=0, timeout_pulse=0, retrain_count=0, timer=0, loss counter=0.
REQ-032 Reset deassertion mid-operation SHALL restart from IDLE; no state is retained.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=16, STATUS_TIMEOUT=32, LOSS_FILTER=3, HOLDOFF_CYCLES=8)
REQ-033 Happy path: cfg_enable=1, block_lock=1 after RESET, status=1 five cycles later -> phy_rst high 4 RESET cycles, states 1->2->3->4, link_up=1, retrain_count=0.
REQ-034 Lock timeout: block_lock held 0 -> WAIT_LOCK lasts 16 cycles, timeout_pulse one cycle, HOLDOFF 8 cycles, RESET again, retrain_count=1.
REQ-035 Loss filter: in UP, rx_high_ber=1 for 2 cycles then 0 -> stays UP; 3 consecutive cycles -> HOLDOFF, link_up=0, retrain_count+1, timeout_pulse=0.
REQ-036 Priority: force_retrain=1 and cfg_enable=0 same cycle in UP -> IDLE, retrain_count unchanged; force_retrain alone -> HOLDOFF next cycle.
REQ-037 Lock drop in WAIT_STATUS at timer=20 -> WAIT_LOCK with timer cleared; 300 HOLDOFF entries -> retrain_count saturates at 255.
REQ-038 Async reset asserted mid-UP, off-edge -> outputs reach REQ-031 values immediately, before next rx_clk edge.

Source files
------------

// File: rtl/eth_phy_10g_link_ctrl.sv
// 10GBASE-R receive link bring-up controller: resets the PHY, waits for block lock and
// receive status, then monitors link quality and retrains through a holdoff period.
module eth_phy_10g_link_ctrl #(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STATUS_TIMEOUT = 8192,
  parameter int LOSS_FILTER    = 4,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic       rx_clk,
  input  logic       rx_rst_n,
  input  logic       cfg_enable,
  input  logic       force_retrain,
  input  logic       rx_block_lock,
  input  logic       rx_status,
  input  logic       rx_high_ber,
  output logic       phy_rst,
  output logic       link_up,
  output logic [2:0] state,
  output logic       timeout_pulse,
  output logic [7:0] retrain_count
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RESET       = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_WAIT_STATUS = 3'd3,
    ST_UP          = 3'd4,
    ST_HOLDOFF     = 3'd5
  } state_e;

  localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST    = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STATUS_LAST  = 16'(STATUS_TIMEOUT - 1);
  localparam logic [15:0] HOLDOFF_LAST = 16'(HOLDOFF_CYCLES - 1);
  localparam logic [7:0]  LOSS_LAST    = 8'(LOSS_FILTER - 1);

  state_e      state_r;
  state_e      next_s;
  logic [15:0] timer_r;
  logic [7:0]  loss_r;
  logic        timeout_s;
  logic        bad_s;
  logic        retrain_ok_s;

  assign bad_s        = ~rx_status | ~rx_block_lock | rx_high_ber;
  assign retrain_ok_s = (state_r == ST_WAIT_LOCK) || (state_r == ST_WAIT_STATUS) || (state_r == ST_UP);
  assign state        = state_r;

  // Next-state selection: disable beats retrain request, which beats timeouts and progress.
  always_comb begin
    next_s    = state_r;
    timeout_s = 1'b0;
    if (!cfg_enable) begin
      next_s = ST_IDLE;
    end else if (force_retrain && retrain_ok_s) begin
      next_s = ST_HOLDOFF;
    end else begin
      case (state_r)
        ST_IDLE: next_s = ST_RESET;
        ST_RESET: begin
          if (timer_r == RST_LAST) next_s = ST_WAIT_LOCK;
          else                     next_s = ST_RESET;
        end
        ST_WAIT_LOCK: begin
          // Lock arriving in the timeout cycle still counts as progress.
          if (rx_block_lock) begin
            next_s = ST_WAIT_STATUS;
          end else if (timer_r == LOCK_LAST) begin
            next_s    = ST_HOLDOFF;
            timeout_s = 1'b1;
          end else begin
            next_s = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_STATUS: begin
          if (!rx_block_lock) begin
            next_s = ST_WAIT_LOCK;
          end else if (rx_status) begin
            next_s = ST_UP;
          end else if (timer_r == STATUS_LAST) begin
            next_s    = ST_HOLDOFF;
            timeout_s = 1'b1;
          end else begin
            next_s = ST_WAIT_STATUS;
          end
        end
        ST_UP: begin
          if (bad_s && (loss_r == LOSS_LAST)) next_s = ST_HOLDOFF;
          else                                next_s = ST_UP;
        end
        ST_HOLDOFF: begin
          if (timer_r == HOLDOFF_LAST) next_s = ST_RESET;
          else                         next_s = ST_HOLDOFF;
        end
        default: next_s = ST_IDLE;
      endcase
    end
  end

  // State, dwell timer, loss filter and registered outputs.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_r       <= ST_IDLE;
      timer_r       <= 16'd0;
      loss_r        <= 8'd0;
      phy_rst       <= 1'b1;
      link_up       <= 1'b0;
      timeout_pulse <= 1'b0;
      retrain_count <= 8'd0;
    end else begin
      state_r <= next_s;
      if (next_s != state_r) begin
        timer_r <= 16'd0;
      end else if (timer_r != 16'hFFFF) begin
        timer_r <= timer_r + 16'd1;
      end else begin
        timer_r <= timer_r;
      end
      // Loss run only persists while staying in UP; any exit or entry restarts it.
      if ((state_r == ST_UP) && (next_s == ST_UP) && bad_s) begin
        loss_r <= (loss_r == 8'hFF) ? loss_r : loss_r + 8'd1;
      end else begin
        loss_r <= 8'd0;
      end
      phy_rst       <= (next_s == ST_IDLE) || (next_s == ST_RESET);
      link_up       <= (next_s == ST_UP);
      timeout_pulse <= timeout_s;
      if ((next_s == ST_HOLDOFF) && (state_r != ST_HOLDOFF) && (retrain_count != 8'hFF)) begin
        retrain_count <= retrain_count + 8'd1;
      end else begin
        retrain_count <= retrain_count;
      end
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Bench for the link controller: directed scenarios plus random traffic, all checked
// every cycle against a dwell-count model of the bring-up rules.
module tb_eth_phy_10g_link_ctrl;

  localparam int P_RST  = 4;
  localparam int P_LOCK = 16;
  localparam int P_STAT = 32;
  localparam int P_LOSS = 3;
  localparam int P_HOLD = 8;

  logic       rx_clk = 1'b0;
  logic       rx_rst_n;
  logic       cfg_enable, force_retrain, rx_block_lock, rx_status, rx_high_ber;
  logic       phy_rst, link_up, timeout_pulse;
  logic [2:0] state;
  logic [7:0] retrain_count;

  int total = 0;
  int bad   = 0;

  // Model: current state, cycles spent in it (1 on entry), bad-cycle run, HOLDOFF entries.
  int m_state, m_cnt, m_run, m_retr;
  bit m_tp;

  always #5 rx_clk = ~rx_clk;

  eth_phy_10g_link_ctrl #(
    .RST_CYCLES(P_RST), .LOCK_TIMEOUT(P_LOCK), .STATUS_TIMEOUT(P_STAT),
    .LOSS_FILTER(P_LOSS), .HOLDOFF_CYCLES(P_HOLD)
  ) dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .cfg_enable(cfg_enable),
    .force_retrain(force_retrain), .rx_block_lock(rx_block_lock),
    .rx_status(rx_status), .rx_high_ber(rx_high_ber), .phy_rst(phy_rst),
    .link_up(link_up), .state(state), .timeout_pulse(timeout_pulse),
    .retrain_count(retrain_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 1; m_run = 0; m_retr = 0; m_tp = 1'b0;
  endtask

  task automatic model_next(input bit en, input bit fr, input bit lk, input bit st, input bit hb);
    int nxt;
    int run_now;
    bit tmo;
    nxt = m_state;
    tmo = 1'b0;
    run_now = (!st || !lk || hb) ? m_run + 1 : 0;
    if (!en) nxt = 0;
    else if (fr && m_state >= 2 && m_state <= 4) nxt = 5;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1) begin
      if (m_cnt == P_RST) nxt = 2;
    end else if (m_state == 2) begin
      if (lk) nxt = 3;
      else if (m_cnt == P_LOCK) begin nxt = 5; tmo = 1'b1; end
    end else if (m_state == 3) begin
      if (!lk) nxt = 2;
      else if (st) nxt = 4;
      else if (m_cnt == P_STAT) begin nxt = 5; tmo = 1'b1; end
    end else if (m_state == 4) begin
      if (run_now == P_LOSS) nxt = 5;
    end else if (m_state == 5) begin
      if (m_cnt == P_HOLD) nxt = 1;
    end else nxt = 0;
    if (nxt == 5 && m_state != 5) m_retr++;
    m_tp    = tmo;
    m_run   = (m_state == 4 && nxt == 4) ? run_now : 0;
    m_cnt   = (nxt != m_state) ? 1 : m_cnt + 1;
    m_state = nxt;
  endtask

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_state));
    chk("phy_rst", 32'(phy_rst), 32'(m_state <= 1));
    chk("link_up", 32'(link_up), 32'(m_state == 4));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
    chk("retrain_count", 32'(retrain_count), 32'((m_retr > 255) ? 255 : m_retr));
  endtask

  // Drive one cycle of inputs at a falling edge, then check just before the next falling edge.
  task automatic step(input bit en, input bit fr, input bit lk, input bit st, input bit hb);
    cfg_enable = en; force_retrain = fr; rx_block_lock = lk; rx_status = st; rx_high_ber = hb;
    model_next(en, fr, lk, st, hb);
    @(negedge rx_clk);
    compare_all();
  endtask

  task automatic run_until(input logic [2:0] s, input bit en, input bit fr, input bit lk,
                           input bit st, input bit hb, input int lim);
    int n;
    n = 0;
    while (state !== s && n < lim) begin
      step(en, fr, lk, st, hb);
      n++;
    end
    chk("reach_state", 32'(state), 32'(s));
  endtask

  task automatic count_in(input logic [2:0] s, input bit en, input bit lk, input bit st,
                          input int lim, output int n);
    n = 0;
    while (state === s && n < lim) begin
      n++;
      step(en, 1'b0, lk, st, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rx_rst_n = 1'b0;
    cfg_enable = 1'b0; force_retrain = 1'b0; rx_block_lock = 1'b0; rx_status = 1'b0; rx_high_ber = 1'b0;
    model_reset();
    repeat (3) @(negedge rx_clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_phy_rst", 32'(phy_rst), 32'd1);
    chk("rst_retrain", 32'(retrain_count), 32'd0);
    rx_rst_n = 1'b1;

    // Happy path: 4 RESET cycles, one WAIT_LOCK, five cycles without status, then UP.
    step(1, 0, 1, 0, 0);
    count_in(3'd1, 1, 1, 0, 20, n);
    chk("reset_cycles", 32'(n), 32'd4);
    chk("after_reset", 32'(state), 32'd2);
    step(1, 0, 1, 0, 0);
    repeat (5) step(1, 0, 1, 0, 0);
    chk("wait_status", 32'(state), 32'd3);
    step(1, 0, 1, 1, 0);
    chk("up_state", 32'(state), 32'd4);
    chk("up_link", 32'(link_up), 32'd1);
    chk("up_retrain", 32'(retrain_count), 32'd0);

    // Lock timeout from a fresh bring-up.
    step(0, 0, 0, 0, 0);
    run_until(3'd2, 1, 0, 0, 0, 0, 50);
    count_in(3'd2, 1, 0, 0, 40, n);
    chk("lock_wait_cycles", 32'(n), 32'd16);
    chk("lock_to_holdoff", 32'(state), 32'd5);
    chk("lock_tpulse", 32'(timeout_pulse), 32'd1);
    chk("lock_retrain", 32'(retrain_count), 32'd1);
    count_in(3'd5, 1, 0, 0, 40, n);
    chk("holdoff_cycles", 32'(n), 32'd8);
    chk("holdoff_to_reset", 32'(state), 32'd1);

    // Loss filter: two bad cycles tolerated, three retrain.
    run_until(3'd4, 1, 0, 1, 1, 0, 100);
    repeat (2) step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 0);
    chk("loss_2_stays_up", 32'(state), 32'd4);
    repeat (3) step(1, 0, 1, 1, 1);
    chk("loss_3_state", 32'(state), 32'd5);
    chk("loss_3_link", 32'(link_up), 32'd0);
    chk("loss_3_retrain", 32'(retrain_count), 32'd2);
    chk("loss_3_tpulse", 32'(timeout_pulse), 32'd0);

    // Disable outranks a simultaneous retrain request.
    run_until(3'd4, 1, 0, 1, 1, 0, 100);
    step(0, 1, 1, 1, 0);
    chk("prio_idle", 32'(state), 32'd0);
    chk("prio_retrain", 32'(retrain_count), 32'd2);
    run_until(3'd4, 1, 0, 1, 1, 0, 100);
    step(1, 1, 1, 1, 0);
    chk("force_holdoff", 32'(state), 32'd5);
    chk("force_retrain", 32'(retrain_count), 32'd3);

    // Asynchronous reset mid-UP, applied between clock edges.
    run_until(3'd4, 1, 0, 1, 1, 0, 100);
    #2 rx_rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_phy_rst", 32'(phy_rst), 32'd1);
    chk("arst_link", 32'(link_up), 32'd0);
    chk("arst_tpulse", 32'(timeout_pulse), 32'd0);
    chk("arst_retrain", 32'(retrain_count), 32'd0);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    model_reset();

    // Lock drop at WAIT_STATUS timer 20 restarts a full WAIT_LOCK window.
    run_until(3'd3, 1, 0, 1, 0, 0, 50);
    repeat (20) step(1, 0, 1, 0, 0);
    chk("ws_at_20", 32'(state), 32'd3);
    step(1, 0, 0, 0, 0);
    count_in(3'd2, 1, 0, 0, 40, n);
    chk("relock_window", 32'(n), 32'd16);

    // 300 retrains saturate the counter.
    for (int i = 0; i < 300; i++) begin
      run_until(3'd2, 1, 0, 0, 0, 0, 50);
      step(1, 1, 0, 0, 0);
    end
    chk("retrain_sat", 32'(retrain_count), 32'd255);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 64) != 0, ($urandom % 40) == 0, ($urandom % 8) != 0,
           ($urandom % 4) != 0, ($urandom % 16) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
